branch_predictor: RTL and testbench

//  Parametrised dynamic branch predictor for the MIPS pipeline: direct-mapped BTB with 2-bit saturating counters plus a return-address stack.
//  IF stage looks up the fetch PC combinationally and gets a predicted direction and target.
//  EX stage feeds back the resolved outcome from the branch judge; the block trains its tables and flags mispredicts for flush.

---
 rtl/branch_predictor.sv | 168 ++++++++++++++++
 tb/tb_branch_predictor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters
// plus a return-address stack (RAS).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   if_pc           - fetch PC looked up combinationally
//   pred_taken      - predicted taken for if_pc
//   pred_target     - predicted target (0 when pred_taken=0)
//   ex_valid        - EX holds a resolved control-transfer instruction
//   ex_pc           - its PC
//   ex_type         - 0=COND 1=JUMP 2=CALL 3=RET
//   ex_taken        - resolved direction
//   ex_target       - resolved target
//   ex_pred_taken   - prediction carried down the pipe
//   ex_pred_target  - predicted target carried down the pipe
//   ex_mispredict   - resolved outcome disagrees with the carried prediction
module branch_predictor #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned RAS_DEPTH = 8,
  parameter logic [1:0]  CNT_INIT  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_type,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] TYPE_COND = 2'd0;
  localparam logic [1:0] TYPE_CALL = 2'd2;
  localparam logic [1:0] TYPE_RET  = 2'd3;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [1:0]         type_q [ENTRIES];
  logic [31:0]        tgt_q  [ENTRIES];
  logic [1:0]         cnt_q  [ENTRIES];

  logic [31:0]        ras_q  [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q;  // next slot to write; top is ptr-1
  logic [CNT_W-1:0]   ras_cnt_q;

  // Address bits [1:0] are always zero for instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [31:0]      ras_top;

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[31:IDX_W+2];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign ras_top = ras_q[ras_ptr_q - 1'b1];

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (lk_hit) begin
      if (type_q[lk_idx] == TYPE_RET) begin
        // A return with nothing on the stack has no usable target.
        if (ras_cnt_q != '0) begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end
      end else if ((type_q[lk_idx] != TYPE_COND) || cnt_q[lk_idx][1]) begin
        pred_taken  = 1'b1;
        pred_target = tgt_q[lk_idx];
      end
    end
  end

  assign ex_mispredict = ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;
  logic             up_tgt_we;
  logic [1:0]       up_cnt;
  logic             ras_push;
  logic             ras_pop;

  assign up_idx = ex_pc[IDX_W+1:2];
  assign up_tag = ex_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    up_cnt    = cnt_q[up_idx];
    up_write  = 1'b0;
    up_tgt_we = 1'b0;
    if (ex_valid) begin
      if (up_hit) begin
        up_write = 1'b1;
        if (ex_type == TYPE_COND) begin
          if (ex_taken) begin
            up_cnt    = (cnt_q[up_idx] == 2'd3) ? 2'd3 : cnt_q[up_idx] + 2'd1;
            up_tgt_we = 1'b1;
          end else begin
            up_cnt = (cnt_q[up_idx] == 2'd0) ? 2'd0 : cnt_q[up_idx] - 2'd1;
          end
        end else begin
          up_cnt    = 2'd3;
          up_tgt_we = 1'b1;
        end
      end else if (ex_taken) begin
        // Only taken transfers are worth a BTB slot.
        up_write  = 1'b1;
        up_tgt_we = 1'b1;
        up_cnt    = (ex_type == TYPE_COND) ? CNT_INIT : 2'd3;
      end
    end
  end

  assign ras_push = ex_valid && (ex_type == TYPE_CALL) && ex_taken;
  assign ras_pop  = ex_valid && (ex_type == TYPE_RET);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (up_write) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        type_q[up_idx]  <= ex_type;
        cnt_q[up_idx]   <= up_cnt;
      end
      if (up_tgt_we) begin
        tgt_q[up_idx] <= ex_target;
      end
      if (ras_push) begin
        // Return lands after the delay slot. A full stack drops its oldest entry.
        ras_q[ras_ptr_q] <= ex_pc + 32'd8;
        ras_ptr_q        <= ras_ptr_q + 1'b1;
        if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
          ras_cnt_q <= ras_cnt_q + 1'b1;
        end
      end else if (ras_pop && (ras_cnt_q != '0)) begin
        ras_ptr_q <= ras_ptr_q - 1'b1;
        ras_cnt_q <= ras_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned ENTRIES   = 64;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned CNT_INIT  = 2;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_type;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_mispredict;

  int errors = 0;
  int checks = 0;

  branch_predictor #(
    .ENTRIES  (ENTRIES),
    .RAS_DEPTH(RAS_DEPTH),
    .CNT_INIT (2'(CNT_INIT))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_type       (ex_type),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_mispredict (ex_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: BTB as an array of records, RAS as a bounded queue.
  typedef struct {
    bit          v;
    int unsigned tag;
    int          ty;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  ent_t        m_btb [ENTRIES];
  logic [31:0] m_ras [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_btb[i].v   = 1'b0;
      m_btb[i].cnt = 0;
    end
    m_ras.delete();
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic t,
                                       output logic [31:0] tg);
    int unsigned i = (pc / 4) % ENTRIES;
    int unsigned tq = pc / (4 * ENTRIES);
    t  = 1'b0;
    tg = '0;
    if (m_btb[i].v && m_btb[i].tag == tq) begin
      if (m_btb[i].ty == 3) begin
        if (m_ras.size() > 0) begin
          t  = 1'b1;
          tg = m_ras[m_ras.size() - 1];
        end
      end else if (m_btb[i].ty != 0 || m_btb[i].cnt >= 2) begin
        t  = 1'b1;
        tg = m_btb[i].tgt;
      end
    end
  endfunction

  function automatic void model_update();
    int unsigned i = (ex_pc / 4) % ENTRIES;
    int unsigned tq = ex_pc / (4 * ENTRIES);
    if (!ex_valid) return;
    if (m_btb[i].v && m_btb[i].tag == tq) begin
      if (ex_type == 0) begin
        if (ex_taken) begin
          m_btb[i].cnt = (m_btb[i].cnt + 1 > 3) ? 3 : m_btb[i].cnt + 1;
          m_btb[i].tgt = ex_target;
        end else begin
          m_btb[i].cnt = (m_btb[i].cnt - 1 < 0) ? 0 : m_btb[i].cnt - 1;
        end
      end else begin
        m_btb[i].cnt = 3;
        m_btb[i].tgt = ex_target;
      end
      m_btb[i].ty = int'(ex_type);
    end else if (ex_taken) begin
      m_btb[i].v   = 1'b1;
      m_btb[i].tag = tq;
      m_btb[i].ty  = int'(ex_type);
      m_btb[i].tgt = ex_target;
      m_btb[i].cnt = (ex_type == 0) ? int'(CNT_INIT) : 3;
    end
    if (ex_type == 2 && ex_taken) begin
      m_ras.push_back(ex_pc + 32'd8);
      if (m_ras.size() > int'(RAS_DEPTH)) void'(m_ras.pop_front());
    end else if (ex_type == 3 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  // One clock: compare outputs mid-cycle against the model, then advance both.
  task automatic cycle(input string tag);
    logic        et;
    logic [31:0] etg;
    logic        em;
    @(negedge clk);
    model_lookup(if_pc, et, etg);
    em = ex_valid && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_target != ex_pred_target));
    check({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, et});
    check({tag, ".pred_target"}, pred_target, etg);
    check({tag, ".mispredict"}, {31'd0, ex_mispredict}, {31'd0, em});
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
  endtask

  task automatic ex_op(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                       input logic [31:0] tgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_type        = ty;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
    cycle("dir");
    ex_valid = 1'b0;
  endtask

  // Directed lookup with a literal expectation; no clock edge inside.
  task automatic look(input string tag, input logic [31:0] pc, input logic t,
                      input logic [31:0] tg);
    ex_valid = 1'b0;
    if_pc    = pc;
    #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
    check({tag, ".target"}, pred_target, tg);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'hBFC0_0000; ex_valid = 1'b0; ex_pc = '0; ex_type = '0;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state
    look("reset", 32'hBFC0_0000, 1'b0, 32'h0);
    check("reset.mispredict", {31'd0, ex_mispredict}, 32'd0);

    // Conditional branch counter training
    ex_op(32'hBFC0_0010, 2'd0, 1'b1, 32'hBFC0_0040);
    look("cond_alloc", 32'hBFC0_0010, 1'b1, 32'hBFC0_0040);
    ex_op(32'hBFC0_0010, 2'd0, 1'b0, 32'hBFC0_0014);
    ex_op(32'hBFC0_0010, 2'd0, 1'b0, 32'hBFC0_0014);
    look("cond_nt2", 32'hBFC0_0010, 1'b0, 32'h0);
    ex_op(32'hBFC0_0010, 2'd0, 1'b1, 32'hBFC0_0040);
    look("cond_t1", 32'hBFC0_0010, 1'b0, 32'h0);
    ex_op(32'hBFC0_0010, 2'd0, 1'b1, 32'hBFC0_0040);
    look("cond_t2", 32'hBFC0_0010, 1'b1, 32'hBFC0_0040);

    // Tag aliasing and no allocation on a not-taken miss
    ex_op(32'h0040_0010, 2'd0, 1'b1, 32'h0040_0800);
    look("alias_miss", 32'h0040_0110, 1'b0, 32'h0);
    ex_op(32'h0040_0110, 2'd0, 1'b0, 32'h0040_0114);
    look("nt_noalloc", 32'h0040_0110, 1'b0, 32'h0);
    look("alias_kept", 32'h0040_0010, 1'b1, 32'h0040_0800);

    // Return predicted from the RAS
    ex_op(32'h0040_0100, 2'd3, 1'b1, 32'h0040_0028);
    look("ret_empty", 32'h0040_0100, 1'b0, 32'h0);
    ex_op(32'h0040_0020, 2'd2, 1'b1, 32'h0040_0200);
    look("ret_top", 32'h0040_0100, 1'b1, 32'h0040_0028);
    ex_op(32'h0040_0100, 2'd3, 1'b1, 32'h0040_0028);
    look("ret_popped", 32'h0040_0100, 1'b0, 32'h0);

    // RAS overflow: 5 pushes into 4 entries, then 5 pops
    for (int i = 0; i < 5; i++) begin
      ex_op(32'h0040_2004 + 32'(i) * 32'h100, 2'd2, 1'b1, 32'h0040_3000);
    end
    for (int i = 4; i >= 0; i--) begin
      if (i >= 1) look("ras_pop", 32'h0040_0100, 1'b1, 32'h0040_200C + 32'(i) * 32'h100);
      else look("ras_empty", 32'h0040_0100, 1'b0, 32'h0);
      ex_op(32'h0040_0100, 2'd3, 1'b1, 32'h0040_0028);
    end
    look("ras_after", 32'h0040_0100, 1'b0, 32'h0);

    // Mispredict flag
    ex_valid = 1'b1; ex_pc = 32'h0040_0300; ex_type = 2'd1; ex_taken = 1'b1;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h40; ex_target = 32'h80;
    #1;
    check("mp_target", {31'd0, ex_mispredict}, 32'd1);
    ex_target = 32'h40;
    #1;
    check("mp_match", {31'd0, ex_mispredict}, 32'd0);
    ex_pred_taken = 1'b0;
    #1;
    check("mp_dir", {31'd0, ex_mispredict}, 32'd1);

    // Reset wins over a same-edge update
    rst = 1'b1;
    ex_pc = 32'h0040_0500; ex_target = 32'h0040_0600;
    cycle("rst_upd");
    rst = 1'b0;
    look("rst_noalloc", 32'h0040_0500, 1'b0, 32'h0);
    look("rst_cleared", 32'h0040_0010, 1'b0, 32'h0);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      pc             = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8)
                       + (32'($urandom_range(0, 7)) << 2);
      ex_pc          = pc;
      ex_type        = pc[3:2];
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_taken       = (pc[3:2] == 2'd0) ? 1'($urandom_range(0, 1)) : 1'b1;
      ex_target      = 32'h0040_1000 + (32'($urandom_range(0, 3)) << 4);
      ex_pred_taken  = 1'($urandom_range(0, 1));
      ex_pred_target = ($urandom_range(0, 1) != 0) ? ex_target : 32'h0040_1040;
      if_pc          = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8)
                       + (32'($urandom_range(0, 7)) << 2);
      rst            = ($urandom_range(0, 79) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
